dram_responder: RTL and testbench

Memory-side responder for the layer engines' DRAM port. It holds the word-addressed feature-map and weight store and serves the conv layer's read and write requests. It also provides a host preload port and a region-clear engine, which zeroes the ofmap partial-sum area before a layer accumulates into it. It sits between the layer engines and the on-chip/behavioural DRAM array and owns all arbitration for the single write port.

---
 rtl/dram_if.sv | 35 +++
 rtl/dram_responder.sv | 111 +++++++++++
 tb/tb_dram_responder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_if.sv
// Bundled request/response signals between the layer engines, host and the DRAM responder.
// The responder takes the slave modport; whatever drives the requests takes master.
interface dram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  clr_start;
  logic [ADDR_WIDTH-1:0] clr_base;
  logic [ADDR_WIDTH-1:0] clr_len;
  logic                  clr_busy;
  logic                  clr_done;
  logic                  err;

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  ld_valid, ld_addr, ld_data, clr_start, clr_base, clr_len,
    output rd_data, ld_ready, clr_busy, clr_done, err
  );

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output ld_valid, ld_addr, ld_data, clr_start, clr_base, clr_len,
    input  rd_data, ld_ready, clr_busy, clr_done, err
  );
endinterface

// File: rtl/dram_responder.sv
// Word-addressed DRAM responder: layer read/write port, host preload and region-clear engine
// sharing one write port (layer > clear > host), with write-first read forwarding.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no clear in progress; clr_start latches base/len
// S_CLEAR | writing zero at ptr each cycle the layer is not writing
// S_DONE  | clear finished; clr_done pulses for this one cycle
module dram_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int MEM_DEPTH  = 32768
) (
  input  logic clk,
  input  logic rst,
  dram_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = MEM_DEPTH[ADDR_WIDTH:0];

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] ptr, cnt;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  err_q;

  logic                  busy, clr_go, ld_go;
  logic                  w_go, w_ok, rd_ok;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  assign busy         = (state != S_IDLE);
  assign bus.clr_busy = busy;
  assign bus.clr_done = (state == S_DONE);
  assign bus.ld_ready = ~bus.wr_en & ~busy;
  assign bus.rd_data  = rd_q;
  assign bus.err      = err_q;

  // Single write port: the layer always wins, the clear engine stalls behind it.
  always_comb begin
    clr_go = (state == S_CLEAR) && !bus.wr_en;
    ld_go  = bus.ld_valid && bus.ld_ready;
    w_go   = 1'b0;
    w_addr = bus.wr_addr;
    w_data = bus.wr_data;
    if (bus.wr_en) begin
      w_go = 1'b1;
    end else if (clr_go) begin
      w_go   = 1'b1;
      w_addr = ptr;
      w_data = '0;
    end else if (ld_go) begin
      w_go   = 1'b1;
      w_addr = bus.ld_addr;
      w_data = bus.ld_data;
    end
    w_ok  = w_go && in_range(w_addr);
    rd_ok = in_range(bus.rd_addr);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.clr_start) state_nx = (bus.clr_len == '0) ? S_DONE : S_CLEAR;
      S_CLEAR: if (clr_go && cnt == ADDR_WIDTH'(1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && bus.clr_start) begin
        ptr <= bus.clr_base;
        cnt <= bus.clr_len;
      end else if (clr_go) begin
        ptr <= ptr + 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ok) mem[w_addr[IDX_W-1:0]] <= w_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (bus.rd_en) begin
        if (!rd_ok)                             rd_q <= '0;
        else if (w_ok && w_addr == bus.rd_addr) rd_q <= w_data;
        else                                    rd_q <= mem[bus.rd_addr[IDX_W-1:0]];
      end
      if ((bus.rd_en && !rd_ok) || (w_go && !w_ok)) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: vector table, clear-timing sequences,
// and random traffic compared against a word-level memory model.
module tb_dram_responder;
  localparam int DW = 32;
  localparam int AW = 18;
  localparam int DEPTH = 32768;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] exp_rd;
    logic          exp_rdy;
  } vec_t;

  vec_t          tv [10];
  logic [DW-1:0] mm [int];
  logic          err_m;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_en = 0; bus.rd_addr = '0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.clr_start = 0; bus.clr_base = '0; bus.clr_len = '0;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    bus.ld_valid = 1; bus.ld_addr = a; bus.ld_data = d;
    #1;
    n = 0;
    while (!bus.ld_ready && n < 50) begin
      step(); n++;
    end
    if (n == 50) chk("host_wr_timeout", 32'(bus.ld_ready), 32'd1);
    step();
    bus.ld_valid = 0;
    mm[int'(a)] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bus.rd_en = 1; bus.rd_addr = a;
    step();
    bus.rd_en = 0;
    d = bus.rd_data;
  endtask

  // Pulses clr_start, optionally stalls with layer writes of 0x10 to 8000,
  // and returns the cycle (relative to clr_start) in which clr_done is seen.
  task automatic run_clear(input logic [AW-1:0] base, input logic [AW-1:0] len,
                           input int st_a, input int st_b,
                           output int done_cyc, output logic rdy_bad, output logic busy1);
    done_cyc = -1; rdy_bad = 0; busy1 = 0;
    bus.clr_base = base; bus.clr_len = len; bus.clr_start = 1;
    step();
    bus.clr_start = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == st_a || k == st_b) begin
        bus.wr_en = 1; bus.wr_addr = 18'd8000; bus.wr_data = 32'h10;
      end else begin
        bus.wr_en = 0;
      end
      #1;
      if (k == 1) busy1 = bus.clr_busy;
      if (bus.ld_ready) rdy_bad = 1;
      if (bus.clr_done) begin
        done_cyc = k;
        break;
      end
      step();
    end
    if (done_cyc == -1) chk("clear_timeout", 32'd0, 32'd1);
    bus.wr_en = 0;
    step();
  endtask

  initial begin
    logic [DW-1:0] d;
    int            dc;
    logic          rb, b1;

    tv[0] = '{1'b0, 18'd0,    1'b1, 18'd5000, 32'h1,    1'b0, 18'd0,    32'h0,        32'h0,        1'b0};
    tv[1] = '{1'b1, 18'd5000, 1'b1, 18'd5000, 32'h1234, 1'b0, 18'd0,    32'h0,        32'h1234,     1'b0};
    tv[2] = '{1'b1, 18'd5000, 1'b0, 18'd0,    32'h0,    1'b0, 18'd0,    32'h0,        32'h1234,     1'b1};
    tv[3] = '{1'b0, 18'd0,    1'b0, 18'd0,    32'h0,    1'b1, 18'd3072, 32'hA5A50001, 32'h1234,     1'b1};
    tv[4] = '{1'b1, 18'd3072, 1'b0, 18'd0,    32'h0,    1'b0, 18'd0,    32'h0,        32'hA5A50001, 1'b1};
    tv[5] = '{1'b0, 18'd3072, 1'b0, 18'd0,    32'h0,    1'b0, 18'd0,    32'h0,        32'hA5A50001, 1'b1};
    tv[6] = '{1'b0, 18'd0,    1'b1, 18'd6000, 32'h77,   1'b1, 18'd6001, 32'h88,       32'hA5A50001, 1'b0};
    tv[7] = '{1'b1, 18'd6001, 1'b0, 18'd0,    32'h0,    1'b1, 18'd6001, 32'h99,       32'h99,       1'b1};
    tv[8] = '{1'b1, 18'd6000, 1'b0, 18'd0,    32'h0,    1'b0, 18'd0,    32'h0,        32'h77,       1'b1};
    tv[9] = '{1'b1, 18'd6001, 1'b0, 18'd0,    32'h0,    1'b0, 18'd0,    32'h0,        32'h99,       1'b1};

    idle_inputs();
    rst = 1;
    repeat (2) step();
    #1;
    chk("reset_rd_data",  bus.rd_data, 32'h0);
    chk("reset_clr_busy", 32'(bus.clr_busy), 32'd0);
    chk("reset_clr_done", 32'(bus.clr_done), 32'd0);
    chk("reset_err",      32'(bus.err), 32'd0);
    chk("reset_ld_ready", 32'(bus.ld_ready), 32'd1);
    step();
    rst = 0;
    step();

    for (int i = 0; i < 10; i++) begin
      bus.rd_en = tv[i].rd_en; bus.rd_addr = tv[i].rd_addr;
      bus.wr_en = tv[i].wr_en; bus.wr_addr = tv[i].wr_addr; bus.wr_data = tv[i].wr_data;
      bus.ld_valid = tv[i].ld_valid; bus.ld_addr = tv[i].ld_addr; bus.ld_data = tv[i].ld_data;
      #1;
      chk($sformatf("vec%0d_ld_ready", i), 32'(bus.ld_ready), 32'(tv[i].exp_rdy));
      step();
      chk($sformatf("vec%0d_rd_data", i), bus.rd_data, tv[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(bus.err), 32'd0);
    end
    idle_inputs();
    step();

    // Clear of 4 words, no stalls
    for (int a = 4096; a <= 4100; a++) host_wr(18'(a), 32'hFFFF_FFFF);
    run_clear(18'd4096, 18'd4, 0, 0, dc, rb, b1);
    chk("clr4_done_cycle", 32'(dc), 32'd5);
    chk("clr4_busy_c1", 32'(b1), 32'd1);
    chk("clr4_ld_ready_low", 32'(rb), 32'd0);
    chk("clr4_busy_after", 32'(bus.clr_busy), 32'd0);
    chk("clr4_done_after", 32'(bus.clr_done), 32'd0);
    for (int a = 4096; a <= 4099; a++) begin
      do_read(18'(a), d);
      chk($sformatf("clr4_word%0d", a), d, 32'h0);
    end
    do_read(18'd4100, d);
    chk("clr4_beyond", d, 32'hFFFF_FFFF);

    // Same clear stalled by two layer writes
    for (int a = 4096; a <= 4100; a++) host_wr(18'(a), 32'hFFFF_FFFF);
    run_clear(18'd4096, 18'd4, 2, 3, dc, rb, b1);
    chk("clrstall_done_cycle", 32'(dc), 32'd7);
    chk("clrstall_ld_ready_low", 32'(rb), 32'd0);
    do_read(18'd8000, d);
    chk("clrstall_layer_word", d, 32'h10);
    for (int a = 4096; a <= 4099; a++) begin
      do_read(18'(a), d);
      chk($sformatf("clrstall_word%0d", a), d, 32'h0);
    end
    do_read(18'd4100, d);
    chk("clrstall_beyond", d, 32'hFFFF_FFFF);

    run_clear(18'd4100, 18'd0, 0, 0, dc, rb, b1);
    chk("clr0_done_cycle", 32'(dc), 32'd1);
    do_read(18'd4100, d);
    chk("clr0_untouched", d, 32'hFFFF_FFFF);

    // Random layer/host traffic against the word model
    for (int a = 9000; a < 9032; a++) host_wr(18'(a), $urandom);
    err_m = 0;
    for (int n = 0; n < 300; n++) begin
      logic re, we, lv, wgo;
      logic [AW-1:0] ra, wa, la, ta;
      logic [DW-1:0] wd, ld, td, exp_rd;
      re = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 2) == 0);
      lv = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 15) == 0) ? 18'(DEPTH + $urandom_range(0, 1000)) : 18'(9000 + $urandom_range(0, 31));
      wa = ($urandom_range(0, 15) == 0) ? 18'(DEPTH + $urandom_range(0, 1000)) : 18'(9000 + $urandom_range(0, 31));
      la = ($urandom_range(0, 15) == 0) ? 18'(DEPTH + $urandom_range(0, 1000)) : 18'(9000 + $urandom_range(0, 31));
      wd = $urandom; ld = $urandom;
      bus.rd_en = re; bus.rd_addr = ra; bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
      bus.ld_valid = lv; bus.ld_addr = la; bus.ld_data = ld;
      #1;
      chk("rand_ld_ready", 32'(bus.ld_ready), 32'(!we));
      wgo = we || lv;
      ta  = we ? wa : la;
      td  = we ? wd : ld;
      exp_rd = bus.rd_data;
      if (re) begin
        if (int'(ra) >= DEPTH)        exp_rd = '0;
        else if (wgo && ta == ra)     exp_rd = td;
        else                          exp_rd = mm[int'(ra)];
      end
      if ((re && int'(ra) >= DEPTH) || (wgo && int'(ta) >= DEPTH)) err_m = 1;
      if (wgo && int'(ta) < DEPTH) mm[int'(ta)] = td;
      step();
      chk("rand_rd_data", bus.rd_data, exp_rd);
      chk("rand_err", 32'(bus.err), 32'(err_m));
    end
    idle_inputs();
    step();

    // Reset in the middle of an 8-word clear
    rst = 1; step(); rst = 0; step();
    for (int a = 0; a < 8; a++) host_wr(18'(4200 + a), 32'(256 + a));
    bus.clr_base = 18'd4200; bus.clr_len = 18'd8; bus.clr_start = 1;
    step();
    bus.clr_start = 0;
    step();
    step();
    chk("midrst_busy_before", 32'(bus.clr_busy), 32'd1);
    rst = 1;
    #1;
    chk("midrst_busy", 32'(bus.clr_busy), 32'd0);
    chk("midrst_done", 32'(bus.clr_done), 32'd0);
    step();
    rst = 0;
    step();
    for (int a = 0; a < 8; a++) begin
      do_read(18'(4200 + a), d);
      chk($sformatf("midrst_word%0d", a), d, (a < 2) ? 32'h0 : 32'(256 + a));
    end

    // Out-of-range read and host write at 40000 (would alias 7232 if not dropped)
    host_wr(18'd7232, 32'h5);
    bus.rd_en = 1; bus.rd_addr = 18'd40000;
    bus.ld_valid = 1; bus.ld_addr = 18'd40000; bus.ld_data = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    chk("oor_rd_data", bus.rd_data, 32'h0);
    chk("oor_err", 32'(bus.err), 32'd1);
    repeat (3) step();
    chk("oor_err_sticky", 32'(bus.err), 32'd1);
    do_read(18'd7232, d);
    chk("oor_no_alias", d, 32'h5);
    chk("oor_err_still", 32'(bus.err), 32'd1);
    rst = 1;
    #1;
    chk("oor_err_cleared", 32'(bus.err), 32'd0);
    step();
    rst = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
